// File: rtl/if_fetch_queue.sv
// if_fetch_queue: owns the PC, issues in-order imem fetches and buffers returned words for ID.
// Optional IF_NOP_FILL_EN: present a NOP with PC 0 on instn/instn_pc while the queue is empty.
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic [31:0] instn,
  output logic        instn_valid,
  output logic [31:0] instn_pc
);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_ipc   [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;

  logic [CW:0]   w_occ;
  logic          w_accept;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_inflight_next;
  logic [31:0]   w_redir_pc;

  // Credit rule: queued plus outstanding words never exceed DEPTH, so a push always has room.
  assign w_occ           = {1'b0, r_count} + {1'b0, r_inflight};
  assign imem_req_valid  = rst_n && !redirect_valid && (w_occ < DEPTH_W);
  assign imem_addr       = r_pc;
  assign w_accept        = imem_req_valid && imem_req_ready;
  assign w_rsp           = imem_rsp_valid && (r_inflight != '0);
  assign w_push          = w_rsp && (r_drop == '0) && !redirect_valid;
  assign w_pop           = instn_valid && !id_stall && !redirect_valid;
  assign w_inflight_next = r_inflight + CW'(w_accept) - CW'(w_rsp);
  assign w_redir_pc      = {redirect_pc[31:2], 2'b00};
  assign instn_valid     = (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
    end else if (redirect_valid) begin
      // Every word still outstanding after this edge belongs to the old path.
      r_pc       <= w_redir_pc;
      r_rsp_pc   <= w_redir_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= w_inflight_next;
      r_drop     <= w_inflight_next;
    end else begin
      if (w_accept) r_pc <= r_pc + 32'd4;
      if (w_push) begin
        r_rsp_pc <= r_rsp_pc + 32'd4;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_inflight <= w_inflight_next;
      if (w_rsp && (r_drop != '0)) r_drop <= r_drop - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_ipc[i]   <= '0;
      end
    end else if (w_push) begin
      r_instr[r_wr_ptr] <= imem_rsp_data;
      r_ipc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

`ifdef IF_NOP_FILL_EN
  assign instn    = instn_valid ? r_instr[r_rd_ptr] : 32'h0000_0000;
  assign instn_pc = instn_valid ? r_ipc[r_rd_ptr]   : 32'h0000_0000;
`else
  assign instn    = r_instr[r_rd_ptr];
  assign instn_pc = r_ipc[r_rd_ptr];
`endif

endmodule
